// File: rtl/hapara_icap_pkg.sv
// Shared state encoding and defaults for the HAPARA ICAP burst controller.
package hapara_icap_pkg;

  localparam int LEN_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_STREAM = 2'd2,
    ST_GAP    = 2'd3
  } icap_state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hapara_icap_rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
module hapara_icap_rr_arbiter import hapara_icap_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    logic found;
    int   cand;
    winner_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_i[IDX_W'(cand)]) begin
        found                   = 1'b1;
        winner_o[IDX_W'(cand)]  = 1'b1;
        idx_o                   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/hapara_icap_burst_ctrl.sv
// Arbitrates bitstream requesters onto one ICAP port and streams each burst
// as registered writes with byte address 4*k, one idle owner gap between bursts.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | sample req, latch round-robin winner and its length
// ST_GRANT  | one cycle of grant; zero length finishes here
// ST_STREAM | s_ready to winner, each handshake becomes an ICAP write
// ST_GAP    | last write / done visible, grant dropped, back to IDLE
module hapara_icap_burst_ctrl import hapara_icap_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  len,
  input  logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  output logic [NUM_REQ-1:0]            s_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          busy,
  output logic                          icap_en,
  output logic [DATA_WIDTH/8-1:0]       icap_we,
  output logic [DATA_WIDTH-1:0]         icap_addr,
  output logic [DATA_WIDTH-1:0]         icap_din
);

  localparam int IDX_W = idx_width(NUM_REQ);

  icap_state_e state_q, state_d;
  logic [NUM_REQ-1:0]      win_oh_q, win_oh_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    widx_q, widx_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    en_q, en_d;
  logic [DATA_WIDTH/8-1:0] we_q, we_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;

  logic [NUM_REQ-1:0]    arb_oh;
  logic [IDX_W-1:0]      arb_idx;
  logic [LEN_WIDTH-1:0]  arb_len;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  xfer;

  hapara_icap_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (arb_oh),
    .idx_o    (arb_idx)
  );

  always_comb begin
    arb_len  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_oh[i])   arb_len  = len[i*LEN_WIDTH +: LEN_WIDTH];
      if (win_oh_q[i]) sel_data = s_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign sel_valid = |(s_valid & win_oh_q);
  assign xfer      = (state_q == ST_STREAM) && sel_valid;

  always_comb begin
    state_d  = state_q;
    win_oh_d = win_oh_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    widx_d   = widx_q;
    done_d   = '0;
    en_d     = 1'b0;
    we_d     = '0;
    addr_d   = addr_q;
    din_d    = din_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_oh_d = arb_oh;
          cnt_d    = arb_len;
          widx_d   = '0;
          ptr_d    = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (cnt_q == '0) begin
          done_d  = win_oh_q;
          state_d = ST_GAP;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          en_d   = 1'b1;
          we_d   = '1;
          din_d  = sel_data;
          addr_d = DATA_WIDTH'({widx_q, 2'b00});
          widx_d = widx_q + LEN_WIDTH'(1);
          cnt_d  = cnt_q - LEN_WIDTH'(1);
          // Terminal count: this handshake carries the last word.
          if (cnt_q == LEN_WIDTH'(1)) begin
            done_d  = win_oh_q;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      win_oh_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      widx_q   <= '0;
      done_q   <= '0;
      en_q     <= 1'b0;
      we_q     <= '0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      win_oh_q <= win_oh_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      widx_q   <= widx_d;
      done_q   <= done_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  assign grant     = ((state_q == ST_GRANT) || (state_q == ST_STREAM)) ? win_oh_q : '0;
  assign s_ready   = (state_q == ST_STREAM) ? win_oh_q : '0;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign icap_en   = en_q;
  assign icap_we   = we_q;
  assign icap_addr = addr_q;
  assign icap_din  = din_q;

endmodule

// File: tb/tb_hapara_icap_burst_ctrl.sv
// Directed bench for the ICAP burst controller: single burst, contention,
// backpressure, zero length, mid-burst reset and request drop.
module tb_hapara_icap_burst_ctrl;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int LW = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*LW-1:0] len = '0;
  logic [NR-1:0]    s_valid = '0;
  logic [NR*DW-1:0] s_data = '0;
  logic [NR-1:0]    s_ready, grant, done;
  logic             busy, icap_en;
  logic [DW/8-1:0]  icap_we;
  logic [DW-1:0]    icap_addr, icap_din;

  int n_chk  = 0;
  int n_pass = 0;

  hapara_icap_burst_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .len       (len),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .icap_en   (icap_en),
    .icap_we   (icap_we),
    .icap_addr (icap_addr),
    .icap_din  (icap_din)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] word_of(input int w, input int k);
    return 32'hA000_0000 | (32'(w) << 16) | 32'(k);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk_eq({tag, "_grant"}, grant, 0);
    chk_eq({tag, "_ready"}, s_ready, 0);
    chk_eq({tag, "_done"}, done, 0);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_en"}, icap_en, 0);
    chk_eq({tag, "_we"}, icap_we, 0);
    chk_eq({tag, "_addr"}, icap_addr, 0);
    chk_eq({tag, "_din"}, icap_din, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    s_valid = '0;
    step();
    step();
    chk_quiet("rst");
    rst = 1'b0;
  endtask

  // One burst from requester w, n words; bp alternates s_valid; req is held
  // until `hold` words have gone (0 drops it right after grant).
  task automatic do_burst(input int w, input int n, input bit bp, input int hold);
    int  sent;
    bit  v;
    req = NR'(1) << w;
    len[w*LW +: LW] = LW'(n);
    step();
    chk_eq("grant", grant, NR'(1) << w);
    chk_eq("grant_en", icap_en, 0);
    chk_eq("grant_busy", busy, 1);
    if (hold == 0) req = '0;
    if (n == 0) begin
      step();
      chk_eq("zl_done", done, NR'(1) << w);
      chk_eq("zl_grant", grant, 0);
      chk_eq("zl_en", icap_en, 0);
      chk_eq("zl_busy", busy, 1);
      step();
      chk_eq("zl_idle_done", done, 0);
      chk_eq("zl_idle_en", icap_en, 0);
      chk_eq("zl_idle_busy", busy, 0);
      return;
    end
    step();
    chk_eq("stream_ready", s_ready, NR'(1) << w);
    chk_eq("stream_en", icap_en, 0);
    sent = 0;
    for (int cyc = 0; sent < n; cyc++) begin
      v = bp ? (cyc % 2 == 0) : 1'b1;
      s_valid = v ? (NR'(1) << w) : '0;
      s_data[w*DW +: DW] = word_of(w, sent);
      step();
      if (v) begin
        chk_eq("wr_en", icap_en, 1);
        chk_eq("wr_we", icap_we, 4'hF);
        chk_eq("wr_addr", icap_addr, 4 * sent);
        chk_eq("wr_din", icap_din, word_of(w, sent));
        sent++;
        if (sent == n) begin
          chk_eq("last_done", done, NR'(1) << w);
          chk_eq("last_grant", grant, 0);
          chk_eq("last_ready", s_ready, 0);
        end else begin
          chk_eq("mid_done", done, 0);
          chk_eq("mid_ready", s_ready, NR'(1) << w);
        end
      end else begin
        chk_eq("idle_en", icap_en, 0);
        chk_eq("idle_we", icap_we, 0);
        chk_eq("idle_ready", s_ready, NR'(1) << w);
      end
      if (sent >= hold) req = '0;
    end
    s_valid = '0;
    step();
    chk_eq("gap_en", icap_en, 0);
    chk_eq("gap_done", done, 0);
    chk_eq("gap_grant", grant, 0);
    chk_eq("gap_busy", busy, 0);
  endtask

  initial begin
    do_reset();

    // Single burst of three words.
    do_burst(0, 3, 1'b0, 0);
    // Zero-length burst from requester 1.
    do_burst(1, 0, 1'b0, 0);
    // Backpressure, four words with alternating valid.
    do_burst(2, 4, 1'b1, 0);

    // Reset after the second word of an 8-word burst.
    req = 4'b0001;
    len[0 +: LW] = 16'd8;
    step();
    chk_eq("mr_grant", grant, 4'b0001);
    req = '0;
    step();
    s_valid = 4'b0001;
    s_data[0 +: DW] = word_of(0, 0);
    step();
    chk_eq("mr_w0_addr", icap_addr, 0);
    s_data[0 +: DW] = word_of(0, 1);
    step();
    chk_eq("mr_w1_addr", icap_addr, 4);
    chk_eq("mr_w1_en", icap_en, 1);
    rst = 1'b1;
    step();
    chk_quiet("mr");
    rst = 1'b0;
    s_valid = '0;
    step();
    chk_eq("mr_after_done", done, 0);
    chk_eq("mr_after_busy", busy, 0);
    // Pointer is back at 0 so requester 3 alone still wins.
    do_burst(3, 2, 1'b0, 0);

    // Contention from reset: 0,1,2,3 each with len 1.
    do_reset();
    req = 4'hF;
    s_valid = 4'hF;
    for (int w = 0; w < NR; w++) begin
      len[w*LW +: LW] = 16'd1;
      s_data[w*DW +: DW] = word_of(w, 0);
    end
    for (int g = 0; g < NR; g++) begin
      step();
      chk_eq("ct_grant", grant, NR'(1) << g);
      chk_eq("ct_grant_en", icap_en, 0);
      step();
      chk_eq("ct_ready", s_ready, NR'(1) << g);
      step();
      chk_eq("ct_en", icap_en, 1);
      chk_eq("ct_din", icap_din, word_of(g, 0));
      chk_eq("ct_addr", icap_addr, 0);
      chk_eq("ct_done", done, NR'(1) << g);
      chk_eq("ct_gap_grant", grant, 0);
      step();
      chk_eq("ct_gap_en", icap_en, 0);
      chk_eq("ct_gap_grant2", grant, 0);
      if (g == NR - 1) req = '0;
    end
    s_valid = '0;
    step();
    chk_eq("ct_end_busy", busy, 0);

    // req0 dropped after word 1 of a 5-word burst; all words still go.
    do_burst(0, 5, 1'b0, 1);

    // Pointer now 1: simultaneous requests 0 and 3 resolve to 3.
    req = 4'b1001;
    len[0 +: LW] = 16'd1;
    len[3*LW +: LW] = 16'd1;
    step();
    chk_eq("rr_grant", grant, 4'b1000);
    req = '0;
    step();
    s_valid = 4'b1000;
    s_data[3*DW +: DW] = word_of(3, 0);
    step();
    chk_eq("rr_done", done, 4'b1000);
    chk_eq("rr_din", icap_din, word_of(3, 0));
    s_valid = '0;
    step();
    chk_eq("rr_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
